lcd_rx: RTL and testbench

LCD_RX -- requirements
Module: lcd_rx

---
 rtl/lcd_rx_if.sv | 33 +++
 rtl/lcd_rx.sv | 159 +++++++++++++++
 tb/tb_lcd_rx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_rx_if.sv
// rtl/lcd_rx_if.sv - LCD nibble-bus capture interface and byte handshake bundle
//
// Signals:
//   lcd_en, lcd_rs, lcd_data : raw HD44780 4-bit bus from the LCD driver (async to clk)
//   rx_data, rx_rs, rx_valid : assembled byte, its register select, and its valid flag
//   rx_ready                 : consumer accept
//   overrun, timeout, rs_mismatch : one-cycle status pulses
// Modports:
//   master : the LCD driver and consumer side (drives the bus, accepts bytes)
//   slave  : the receiver side (lcd_rx)

interface lcd_rx_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic [3:0] lcd_data;
  logic [7:0] rx_data;
  logic       rx_rs;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       timeout;
  logic       rs_mismatch;

  modport master (
    output lcd_en, lcd_rs, lcd_data, rx_ready,
    input  rx_data, rx_rs, rx_valid, overrun, timeout, rs_mismatch
  );

  modport slave (
    input  lcd_en, lcd_rs, lcd_data, rx_ready,
    output rx_data, rx_rs, rx_valid, overrun, timeout, rs_mismatch
  );
endinterface

// File: rtl/lcd_rx.sv
// rtl/lcd_rx.sv - HD44780 4-bit bus snooper assembling nibble pairs into bytes
//
// Ports:
//   clk   : single clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : lcd_rx_if.slave (LCD bus in, byte handshake and status pulses out)
// Parameter:
//   TIMEOUT : clocks allowed between high- and low-nibble strobes (>= 1)
//
// Pipeline: 2-flop synchronizers -> en_prev/nibble capture -> nibble FSM
// (registers a completed byte) -> holding register with valid/ready.

module lcd_rx #(
  parameter int TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     reset,
  lcd_rx_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic {HI, LO} state_t;

  // synchronizers and previous-value capture
  logic       en_s1, en_s2, en_prev;
  logic       rs_s1, rs_s2, rs_prev;
  logic [3:0] d_s1, d_s2, d_prev;

  // nibble FSM
  state_t     state;
  logic [TW-1:0] timer;
  logic [3:0] hi_q;
  logic       hi_rs_q;
  logic       done_q;
  logic [7:0] done_byte_q;
  logic       done_rs_q;
  logic       done_mis_q;
  logic       timeout_q;

  // holding register
  logic [7:0] rx_data_q;
  logic       rx_rs_q;
  logic       rx_valid_q;
  logic       overrun_q;
  logic       rs_mismatch_q;

  logic strobe;

  // Falling edge of the synchronized enable: the HD44780 latches here, so the
  // nibble is the value captured alongside en_prev (last value while en was high).
  assign strobe = en_prev & ~en_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_prev <= 1'b0;
      rs_s1   <= 1'b0;
      rs_s2   <= 1'b0;
      rs_prev <= 1'b0;
      d_s1    <= 4'h0;
      d_s2    <= 4'h0;
      d_prev  <= 4'h0;
    end else begin
      en_s1   <= bus.lcd_en;
      en_s2   <= en_s1;
      en_prev <= en_s2;
      rs_s1   <= bus.lcd_rs;
      rs_s2   <= rs_s1;
      rs_prev <= rs_s2;
      d_s1    <= bus.lcd_data;
      d_s2    <= d_s1;
      d_prev  <= d_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HI;
      timer       <= '0;
      hi_q        <= 4'h0;
      hi_rs_q     <= 1'b0;
      done_q      <= 1'b0;
      done_byte_q <= 8'h00;
      done_rs_q   <= 1'b0;
      done_mis_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_mis_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        HI: begin
          if (strobe) begin
            hi_q    <= d_prev;
            hi_rs_q <= rs_prev;
            timer   <= '0;
            state   <= LO;
          end
        end
        LO: begin
          // Strobe is tested first so a strobe coinciding with expiry completes the byte.
          if (strobe) begin
            done_q      <= 1'b1;
            done_byte_q <= {hi_q, d_prev};
            done_rs_q   <= hi_rs_q;
            done_mis_q  <= (hi_rs_q != rs_prev);
            state       <= HI;
          end else if (timer == TMAX) begin
            timeout_q <= 1'b1;
            hi_q      <= 4'h0;
            hi_rs_q   <= 1'b0;
            timer     <= '0;
            state     <= HI;
          end else begin
            // never passes TMAX: expiry above leaves LO first
            timer <= timer + 1'b1;
          end
        end
        default: state <= HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q     <= 8'h00;
      rx_rs_q       <= 1'b0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      rs_mismatch_q <= 1'b0;
    end else begin
      overrun_q     <= 1'b0;
      rs_mismatch_q <= done_mis_q;
      if (done_q) begin
        // A byte completing in the same cycle the old one is accepted replaces it.
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= done_byte_q;
          rx_rs_q    <= done_rs_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_rs       = rx_rs_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout     = timeout_q;
  assign bus.rs_mismatch = rs_mismatch_q;

endmodule

// File: tb/tb_lcd_rx.sv
// tb/tb_lcd_rx.sv - self-checking bench for lcd_rx

module tb_lcd_rx;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  lcd_rx_if bus();

  lcd_rx #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pulse counters and accepted-byte log {rs, data}
  int ovr_cnt, to_cnt, mis_cnt;
  logic [8:0] got[$];
  logic ovr_d, to_d, mis_d;

  initial begin
    ovr_cnt = 0; to_cnt = 0; mis_cnt = 0;
    ovr_d = 0; to_d = 0; mis_d = 0;
  end

  always @(negedge clk) begin
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (bus.timeout === 1'b1) to_cnt++;
    if (bus.rs_mismatch === 1'b1) mis_cnt++;
    if ((bus.overrun === 1'b1 && ovr_d) || (bus.timeout === 1'b1 && to_d) ||
        (bus.rs_mismatch === 1'b1 && mis_d)) begin
      checks++;
      errors++;
      $display("FAIL pulse_width: pulse high two cycles (ovr=%b to=%b mis=%b), required one cycle",
               bus.overrun, bus.timeout, bus.rs_mismatch);
    end
    ovr_d = (bus.overrun === 1'b1);
    to_d  = (bus.timeout === 1'b1);
    mis_d = (bus.rs_mismatch === 1'b1);
    if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1)
      got.push_back({bus.rx_rs, bus.rx_data});
  end

  // One nibble transfer meeting upstream timing. If ready_edge > 0, rx_ready is
  // asserted so that it is sampled on the ready_edge-th rising edge after en falls.
  task automatic send_nibble(input logic rs, input logic [3:0] d, input int ready_edge);
    @(negedge clk);
    bus.lcd_rs   = rs;
    bus.lcd_data = d;
    repeat (3) @(negedge clk);
    bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_en = 1'b0;
    if (ready_edge > 0) begin
      repeat (ready_edge - 1) @(negedge clk);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      repeat (4 - ready_edge) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic accept_one();
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.lcd_en = ~bus.lcd_en;
      bus.lcd_data = 4'($urandom_range(0, 15));
    end
    bus.lcd_en = 1'b0;
    checks++;
    if ({bus.rx_data, bus.rx_rs, bus.rx_valid, bus.overrun, bus.timeout, bus.rs_mismatch} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h rs=%b valid=%b ovr=%b to=%b mis=%b, required all 0",
               bus.rx_data, bus.rx_rs, bus.rx_valid, bus.overrun, bus.timeout, bus.rs_mismatch);
    end
    checks++;
    if (ovr_cnt + to_cnt + mis_cnt !== 0) begin
      errors++;
      $display("FAIL reset_pulses: %0d pulses seen in reset, required 0", ovr_cnt + to_cnt + mis_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_byte();
    int lat;
    bus.rx_ready = 1'b0;
    send_nibble(1'b1, 4'h4, 0);
    @(negedge clk);
    bus.lcd_rs = 1'b1;
    bus.lcd_data = 4'h1;
    repeat (3) @(negedge clk);
    bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.lcd_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.rx_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL byte_latency: rx_valid after %0d edges (0 = never), required 4", lat);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (bus.rx_data !== 8'h41 || bus.rx_rs !== 1'b1 || bus.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL byte_held: data=%h rs=%b valid=%b, required 41 1 1",
               bus.rx_data, bus.rx_rs, bus.rx_valid);
    end
    accept_one();
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL byte_accept: valid=%b after accept, required 0", bus.rx_valid);
    end
  endtask

  task automatic test_rs_mismatch();
    int m0;
    m0 = mis_cnt;
    send_nibble(1'b0, 4'h3, 0);
    send_nibble(1'b1, 4'h8, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rx_data !== 8'h38 || bus.rx_rs !== 1'b0 || bus.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_byte: data=%h rs=%b valid=%b, required 38 0 1",
               bus.rx_data, bus.rx_rs, bus.rx_valid);
    end
    checks++;
    if (mis_cnt - m0 !== 1) begin
      errors++;
      $display("FAIL mismatch_pulse: %0d pulses, required 1", mis_cnt - m0);
    end
    accept_one();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = to_cnt;
    send_nibble(1'b0, 4'h3, 0);
    repeat (20) @(negedge clk);
    checks++;
    if (to_cnt - t0 !== 1 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: %0d pulses valid=%b, required 1 pulse valid 0", to_cnt - t0, bus.rx_valid);
    end
    send_nibble(1'b0, 4'h2, 0);
    send_nibble(1'b0, 4'h8, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rx_data !== 8'h28 || bus.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover: data=%h valid=%b, required 28 1", bus.rx_data, bus.rx_valid);
    end
    accept_one();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    got.delete();
    bus.rx_ready = 1'b0;
    send_nibble(1'b1, 4'h4, 0);
    send_nibble(1'b1, 4'h1, 0);
    send_nibble(1'b1, 4'h4, 0);
    send_nibble(1'b1, 4'h2, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rx_data !== 8'h41 || bus.rx_valid !== 1'b1 || ovr_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_drop: data=%h valid=%b ovr=%0d, required 41 1 1",
               bus.rx_data, bus.rx_valid, ovr_cnt - o0);
    end
    // second pass: accept 0x41 on the exact cycle 0x42 completes
    send_nibble(1'b1, 4'h4, 0);
    send_nibble(1'b1, 4'h2, 4);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rx_data !== 8'h42 || bus.rx_valid !== 1'b1 || ovr_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_replace: data=%h valid=%b ovr=%0d, required 42 1 1",
               bus.rx_data, bus.rx_valid, ovr_cnt - o0);
    end
    checks++;
    if (got.size() !== 1 || got[0] !== 9'h141) begin
      errors++;
      $display("FAIL overrun_accepted: %0d bytes first=%h, required 1 byte 141",
               got.size(), (got.size() > 0) ? got[0] : 9'h0);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    send_nibble(1'b0, 4'h5, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    t0 = to_cnt;
    @(negedge clk);
    checks++;
    if (bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: valid=%b, required 0", bus.rx_valid);
    end
    send_nibble(1'b0, 4'h6, 0);
    send_nibble(1'b0, 4'h7, 0);
    repeat (25) @(negedge clk);
    checks++;
    if (bus.rx_data !== 8'h67 || bus.rx_valid !== 1'b1 || to_cnt !== t0) begin
      errors++;
      $display("FAIL reset_mid_byte: data=%h valid=%b timeouts=%0d, required 67 1 0",
               bus.rx_data, bus.rx_valid, to_cnt - t0);
    end
    accept_one();
  endtask

  // Random nibble pairs back to back with the consumer always ready; the
  // expected stream is just hi*16+lo with the first nibble's rs.
  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    int exp_mis, m0;
    logic [3:0] h, l;
    logic r1, r2;
    got.delete();
    m0 = mis_cnt;
    exp_mis = 0;
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      h  = 4'($urandom_range(0, 15));
      l  = 4'($urandom_range(0, 15));
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      exp_q.push_back({r1, 8'(h * 16 + l)});
      if (r1 != r2) exp_mis++;
      send_nibble(r1, h, 0);
      send_nibble(r2, l, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    bus.rx_ready = 1'b0;
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: %0d bytes, required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (mis_cnt - m0 !== exp_mis) begin
      errors++;
      $display("FAIL b2b_mismatch: %0d pulses, required %0d", mis_cnt - m0, exp_mis);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.lcd_en = 1'b0;
    bus.lcd_rs = 1'b0;
    bus.lcd_data = 4'h0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_byte();
    test_rs_mismatch();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
